riscv_core_div_iter: RTL and testbench
======================================

Name: riscv_core_div_iter

Overview:
Iterative radix-2 restoring divider core for the M-extension divide path. It sits directly upstream of the divide output stage.
- Takes issued operands and converts them to unsigned magnitudes.
- Produces the unsigned quotient and remainder magnitudes, plus a one-cycle done pulse.
- Sign correction, word sign-extension and all special-case results are applied downstream, not here.
- Divide-by-zero and signed-overflow cases never start an iteration, because the output stage finishes those on start.

Parameters:
XLEN, 64, datapath width; word ops use XLEN/2.

Ports:
i_div_iter_clk  input  1  clock
i_div_iter_rstn  input  1  asynchronous active-low reset
i_div_iter_start  input  1  start pulse; operands valid this cycle
i_div_iter_flush  input  1  pipeline kill; aborts any operation
i_div_iter_srcA  input  XLEN  dividend
i_div_iter_srcB  input  XLEN  divisor
i_div_iter_control  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; bit0=1 means unsigned
i_div_iter_isword  input  1  RV64 W-variant
o_div_iter_busy  output  1  iteration in progress
o_div_iter_done  output  1  one-cycle pulse; magnitudes valid
o_div_iter_quotient  output  XLEN  unsigned quotient magnitude
o_div_iter_remainder  output  XLEN  unsigned remainder magnitude

Behaviour:
- Reset (async, active-low): state IDLE; busy=0, done=0, quotient=0, remainder=0; counter and internal registers cleared.
- States:
  - IDLE: on start & ~flush & ~special, latch magnitudes, load counter=N, go to CALC. Otherwise stay in IDLE.
  - CALC: perform one restoring step per cycle and decrement the counter. When counter reaches 1, the step executes and the state goes to DONE. flush goes to IDLE.
  - DONE: done=1 for exactly one cycle, then IDLE. flush in DONE suppresses done.
- special = (srcB == 0) | (~control[0] & srcA == 0x8000_0000_0000_0000 & srcB == all-ones).
  - The compare is on the full XLEN operands, including for W ops, identical to the output stage.
  - When special, the block stays IDLE and done never pulses for that operation.
- N = XLEN for non-word ops, XLEN/2 for word ops.
- Latency: start sampled at edge k; done is high in the cycle after edge k+N+1 (64-bit: 65 cycles; word: 33 cycles).
- busy is high from edge k+1 until DONE is exited.
- Magnitudes:
  - Unsigned ops: operands are zero-extended; word ops use the [31:0] slices.
  - Signed non-word: |A| and |B| as XLEN-bit unsigned values; |0x8000_0000_0000_0000| = 2^63.
  - Signed word: take the two's-complement magnitude of the [31:0] slice as a 32-bit unsigned value (|0x8000_0000| = 2^31), then zero-extend.
- Step: the partial remainder P is XLEN+1 bits. Shift {P, Q} left by 1, then trial-subtract |B|.
  - If the result is non-negative, P = difference and Q[0] = 1.
  - Otherwise P is restored and Q[0] = 0.
- Outputs:
  - quotient = Q and remainder = P[XLEN-1:0], registered and held stable from done until the next accepted start.
  - Word results occupy [31:0] with the upper half zero.
- start while busy or in DONE: ignored, with no effect on the running operation.
- The issuer holds srcA, srcB, control and isword stable from start through done, because downstream sign logic reads them combinationally.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.
- Simultaneous start & flush in IDLE: flush wins and nothing starts.

Decomposition:
- Shared package (riscv_core_pkg):
  - div control encodings DIV, DIVU, REM, REMU;
  - OVERFLOW_SIGNED_A and OVERFLOW_SIGNED_B constants;
  - the div_state_t enum (IDLE, CALC, DONE).
- Sub-module riscv_core_div_abs: operand magnitude extraction (signed/unsigned, word/dword), combinational, one instance per operand.

Test Plan:
- DIVU 64-bit: A=100, B=7, start -> done in the 65th cycle after start, quotient=14, remainder=2, busy high for 64 cycles.
- DIV: A=-100, B=7 -> quotient=14, remainder=2 (magnitudes).
- DIVW: A=0xFFFFFFFF80000000, B=0xFFFFFFFFFFFFFFFF -> done after 33 cycles, quotient=0x0000000080000000, remainder=0.
- Special cases:
  - B=0 with any control: no busy, no done pulse in 100 cycles.
  - DIV with A=0x8000000000000000, B=-1: same, no busy and no done.
- Start A=100, B=7, then a second start at cycle 10 with A=9, B=3 -> the second start is ignored; result is 14/2.
- Flush at cycle 20 of a 64-bit op: busy drops the next cycle, no done pulse. rstn low mid-CALC: outputs are 0 asynchronously.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared encodings and state types for the riscv_core divide path.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_ctrl_t;

    localparam logic [63:0] OVERFLOW_SIGNED_A = 64'h8000_0000_0000_0000;
    localparam logic [63:0] OVERFLOW_SIGNED_B = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/riscv_core_div_abs.sv
// Operand magnitude extraction for the divider (signed/unsigned, word/dword).
module riscv_core_div_abs #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] val,
    input  logic            is_signed,
    input  logic            is_word,
    output logic [XLEN-1:0] mag
);

    localparam int H = XLEN / 2;

    logic [H-1:0]    w_neg;
    logic [XLEN-1:0] d_neg;

    assign w_neg = -val[H-1:0];
    assign d_neg = -val;

    always_comb begin
        mag = val;
        if (is_word) begin
            mag = {{H{1'b0}}, (is_signed & val[H-1]) ? w_neg : val[H-1:0]};
        end else if (is_signed & val[XLEN-1]) begin
            mag = d_neg;
        end
    end

endmodule

// File: rtl/riscv_core_div_iter.sv
// Iterative radix-2 restoring divider producing unsigned quotient/remainder
// magnitudes; sign fix-up and special cases are handled by the output stage.
module riscv_core_div_iter
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_div_iter_clk,
    input  logic            i_div_iter_rstn,
    input  logic            i_div_iter_start,
    input  logic            i_div_iter_flush,
    input  logic [XLEN-1:0] i_div_iter_srcA,
    input  logic [XLEN-1:0] i_div_iter_srcB,
    input  logic [1:0]      i_div_iter_control,
    input  logic            i_div_iter_isword,
    output logic            o_div_iter_busy,
    output logic            o_div_iter_done,
    output logic [XLEN-1:0] o_div_iter_quotient,
    output logic [XLEN-1:0] o_div_iter_remainder
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] OVF_A = OVERFLOW_SIGNED_A[63 -: XLEN];
    localparam logic [XLEN-1:0] OVF_B = OVERFLOW_SIGNED_B[XLEN-1:0];

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   shifted, diff;
    logic            is_signed, special, fin;

    assign is_signed = (i_div_iter_control == DIV) | (i_div_iter_control == REM);

    assign special = (i_div_iter_srcB == '0) |
                     (~i_div_iter_control[0] &
                      (i_div_iter_srcA == OVF_A) &
                      (i_div_iter_srcB == OVF_B));

    riscv_core_div_abs #(.XLEN(XLEN)) u_abs_a (
        .val       (i_div_iter_srcA),
        .is_signed (is_signed),
        .is_word   (i_div_iter_isword),
        .mag       (a_mag)
    );

    riscv_core_div_abs #(.XLEN(XLEN)) u_abs_b (
        .val       (i_div_iter_srcB),
        .is_signed (is_signed),
        .is_word   (i_div_iter_isword),
        .mag       (b_mag)
    );

    // Partial remainder never exceeds the divisor, so its top bit lives only in the step.
    assign shifted = {p_q, q_q[XLEN-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign fin     = (state_q == DONE) & ~i_div_iter_flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (i_div_iter_start & ~i_div_iter_flush & ~special) begin
                    state_d = CALC;
                    cnt_d   = i_div_iter_isword ? CW'(XLEN / 2) : CW'(XLEN);
                    p_d     = '0;
                    // Word dividends sit in the upper half so the same MSB feeds P.
                    q_d     = i_div_iter_isword ? (a_mag << (XLEN / 2)) : a_mag;
                    b_d     = b_mag;
                end
            end
            CALC: begin
                if (i_div_iter_flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (diff[XLEN]) begin
                        p_d = shifted[XLEN-1:0];
                        q_d = {q_q[XLEN-2:0], 1'b0};
                    end else begin
                        p_d = diff[XLEN-1:0];
                        q_d = {q_q[XLEN-2:0], 1'b1};
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_div_iter_clk or negedge i_div_iter_rstn) begin
        if (!i_div_iter_rstn) begin
            state_q              <= IDLE;
            cnt_q                <= '0;
            p_q                  <= '0;
            q_q                  <= '0;
            b_q                  <= '0;
            o_div_iter_busy      <= 1'b0;
            o_div_iter_done      <= 1'b0;
            o_div_iter_quotient  <= '0;
            o_div_iter_remainder <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            p_q             <= p_d;
            q_q             <= q_d;
            b_q             <= b_d;
            o_div_iter_busy <= (state_q == CALC) & ~i_div_iter_flush;
            o_div_iter_done <= fin;
            if (fin) begin
                o_div_iter_quotient  <= q_q;
                o_div_iter_remainder <= p_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_div_iter.sv
// Scoreboard bench for riscv_core_div_iter.
module tb_riscv_core_div_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        isword = 1'b0;
    logic [1:0]  ctrl = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy, done;
    logic [63:0] quo, rem;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int errors = 0;
    int checks = 0;
    int dcyc, bcnt, dcnt;
    logic [63:0] qd, rd;

    always #5 clk = ~clk;

    riscv_core_div_iter #(.XLEN(64)) dut (
        .i_div_iter_clk       (clk),
        .i_div_iter_rstn      (rstn),
        .i_div_iter_start     (start),
        .i_div_iter_flush     (flush),
        .i_div_iter_srcA      (a),
        .i_div_iter_srcB      (b),
        .i_div_iter_control   (ctrl),
        .i_div_iter_isword    (isword),
        .o_div_iter_busy      (busy),
        .o_div_iter_done      (done),
        .o_div_iter_quotient  (quo),
        .o_div_iter_remainder (rem)
    );

    function automatic logic [63:0] mag(input logic [63:0] v, input bit sgn, input bit w);
        logic [31:0] lo;
        lo = v[31:0];
        if (w) begin
            if (sgn && lo[31]) lo = ~lo + 32'd1;
            return {32'd0, lo};
        end
        if (sgn && v[63]) return ~v + 64'd1;
        return v;
    endfunction

    task automatic launch(input logic [63:0] va, input logic [63:0] vb,
                          input logic [1:0] c, input bit w, input bit push);
        logic [63:0] ma, mb;
        @(posedge clk); #1;
        a = va; b = vb; ctrl = c; isword = w; start = 1'b1;
        if (push) begin
            ma = mag(va, ~c[0], w);
            mb = mag(vb, ~c[0], w);
            sb.push_back('{ma / mb, ma % mb});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_cycles(input int limit, input int inj_at, input int fl_at);
        dcyc = -1; bcnt = 0; dcnt = 0; qd = '0; rd = '0;
        for (int c = 0; c <= limit; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            flush = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin
                    dcyc = c; qd = quo; rd = rem;
                end
            end
            if (c == inj_at) begin
                start = 1'b1; a = 64'd9; b = 64'd3;
            end
            if (c == fl_at) flush = 1'b1;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (quo !== 64'd0) begin errors++; $display("FAIL reset_quo got=%h exp=0", quo); end
        checks++;
        if (rem !== 64'd0) begin errors++; $display("FAIL reset_rem got=%h exp=0", rem); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_divu;
        launch(64'd100, 64'd7, 2'b01, 1'b0, 1'b1);
        run_cycles(70, -1, -1);
        checks++;
        if (dcyc != 65) begin errors++; $display("FAIL divu_latency got=%0d exp=65", dcyc); end
        checks++;
        if (bcnt != 64) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=64", bcnt); end
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL divu_done_pulses got=%0d exp=1", dcnt); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q) begin errors++; $display("FAIL divu_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r) begin errors++; $display("FAIL divu_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_div_signed;
        launch(-64'sd100, 64'd7, 2'b00, 1'b0, 1'b1);
        run_cycles(70, -1, -1);
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL div_done_pulses got=%0d exp=1", dcnt); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q || qd !== 64'd14) begin errors++; $display("FAIL div_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r || rd !== 64'd2) begin errors++; $display("FAIL div_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_divw;
        launch(64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 1'b1);
        run_cycles(40, -1, -1);
        checks++;
        if (dcyc != 33) begin errors++; $display("FAIL divw_latency got=%0d exp=33", dcyc); end
        checks++;
        if (bcnt != 32) begin errors++; $display("FAIL divw_busy_cycles got=%0d exp=32", bcnt); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q || qd !== 64'h8000_0000) begin errors++; $display("FAIL divw_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r) begin errors++; $display("FAIL divw_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_special;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) launch({$urandom, $urandom}, 64'd0, 2'(c), c[0], 1'b0);
            else launch(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b0);
            run_cycles(100, -1, -1);
            checks++;
            if (bcnt != 0) begin errors++; $display("FAIL special%0d_busy got=%0d exp=0", c, bcnt); end
            checks++;
            if (dcnt != 0) begin errors++; $display("FAIL special%0d_done got=%0d exp=0", c, dcnt); end
        end
        launch(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 1'b1);
        run_cycles(70, -1, -1);
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL remu_ovf_done got=%0d exp=1", dcnt); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q) begin errors++; $display("FAIL remu_ovf_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r) begin errors++; $display("FAIL remu_ovf_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_back_to_back;
        launch(64'd100, 64'd7, 2'b01, 1'b0, 1'b1);
        run_cycles(70, 10, -1);
        checks++;
        if (dcyc != 65) begin errors++; $display("FAIL b2b_latency got=%0d exp=65", dcyc); end
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", dcnt); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q) begin errors++; $display("FAIL b2b_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r) begin errors++; $display("FAIL b2b_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_flush;
        launch(64'd1000, 64'd3, 2'b01, 1'b0, 1'b0);
        run_cycles(70, -1, 20);
        checks++;
        if (bcnt != 20) begin errors++; $display("FAIL flush_busy_cycles got=%0d exp=20", bcnt); end
        checks++;
        if (dcnt != 0) begin errors++; $display("FAIL flush_done got=%0d exp=0", dcnt); end
    endtask

    task automatic test_reset_mid;
        launch(64'd12345, 64'd11, 2'b01, 1'b0, 1'b0);
        run_cycles(10, -1, -1);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++;
        if (quo !== 64'd0) begin errors++; $display("FAIL rstmid_quo got=%h exp=0", quo); end
        checks++;
        if (rem !== 64'd0) begin errors++; $display("FAIL rstmid_rem got=%h exp=0", rem); end
        @(posedge clk); #1;
        rstn = 1'b1;
        launch(64'd1003, 64'd10, 2'b11, 1'b0, 1'b1);
        run_cycles(70, -1, -1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (qd !== e.q) begin errors++; $display("FAIL post_rst_quo got=%h exp=%h", qd, e.q); end
            checks++;
            if (rd !== e.r) begin errors++; $display("FAIL post_rst_rem got=%h exp=%h", rd, e.r); end
        end
    endtask

    task automatic test_random;
        logic [63:0] ra, rb;
        bit w;
        for (int i = 0; i < 8; i++) begin
            w  = (i >= 4);
            ra = {$urandom, $urandom};
            rb = (i % 2 == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            rb[0] = 1'b1;
            if (ra == 64'h8000_0000_0000_0000 && rb == '1) rb = 64'd3;
            launch(ra, rb, 2'(i % 4), w, 1'b1);
            run_cycles(70, -1, -1);
            checks++;
            if (dcyc != (w ? 33 : 65)) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, dcyc, w ? 33 : 65); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (qd !== e.q) begin errors++; $display("FAIL rnd%0d_quo got=%h exp=%h", i, qd, e.q); end
                checks++;
                if (rd !== e.r) begin errors++; $display("FAIL rnd%0d_rem got=%h exp=%h", i, rd, e.r); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_div_signed;
        test_divw;
        test_special;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_random;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
